// File: rtl/restador_recuperador.sv
// restador_recuperador: recovers dataA = (sum30_dd - dataB) mod 16 from a tag-indexed dataB buffer
//   clk, reset_L (async active-low)
//   wr_valid/idx/dataB       : store dataB under tag idx
//   rd_valid/idx_dd/sum30_dd : sumador result arriving with its tag
//   dataA_rec/idx_rec/valid_rec : registered recovered operand
//   miss (pulse), overwrite (sticky), cnt_rec (wrapping hit count)
//   RESTADOR_MISSCNT_EN : adds miss_cnt, saturating count of misses
module restador_recuperador (
    input  logic       clk,
    input  logic       reset_L,
    input  logic       wr_valid,
    input  logic [3:0] idx,
    input  logic [3:0] dataB,
    input  logic       rd_valid,
    input  logic [3:0] idx_dd,
    input  logic [3:0] sum30_dd,
    output logic [3:0] dataA_rec,
    output logic [3:0] idx_rec,
    output logic       valid_rec,
    output logic       miss,
    output logic       overwrite,
    output logic [7:0] cnt_rec
`ifdef RESTADOR_MISSCNT_EN
    ,
    output logic [7:0] miss_cnt
`endif
);
    typedef enum logic {RST, RUN} state_t;
    state_t     state, state_nx;
    logic [3:0] mem [16];
    logic [15:0] occ, occ_nx;
    logic       run, wr, rd, same, hit;
    logic [3:0] b_rd;
    always_ff @(posedge clk or negedge reset_L)
        if (!reset_L) state <= RST;
        else          state <= state_nx;
    // The first edge after reset only moves RST->RUN; inputs are gated until RUN.
    always_comb begin
        state_nx = RUN;
        run      = state == RUN;
        wr       = run & wr_valid;
        rd       = run & rd_valid;
        same     = wr & rd & (idx == idx_dd);
        hit      = rd & (occ[idx_dd] | same);
        b_rd     = same ? dataB : mem[idx_dd];
        occ_nx   = occ;
        if (wr)  occ_nx[idx] = 1'b1;
        if (hit) occ_nx[idx_dd] = 1'b0;
    end
    always_ff @(posedge clk)
        if (wr) mem[idx] <= dataB;
    always_ff @(posedge clk or negedge reset_L)
        if (!reset_L) begin
            occ       <= '0;
            dataA_rec <= '0;
            idx_rec   <= '0;
            valid_rec <= 1'b0;
            miss      <= 1'b0;
            overwrite <= 1'b0;
            cnt_rec   <= '0;
        end else begin
            occ       <= occ_nx;
            valid_rec <= hit;
            miss      <= rd & ~hit;
            overwrite <= overwrite | (wr & occ[idx] & ~same);
            if (hit) begin
                dataA_rec <= sum30_dd - b_rd;
                idx_rec   <= idx_dd;
                cnt_rec   <= cnt_rec + 8'd1;
            end
        end
`ifdef RESTADOR_MISSCNT_EN
    always_ff @(posedge clk or negedge reset_L)
        if (!reset_L)                               miss_cnt <= '0;
        else if (rd & ~hit & (miss_cnt != 8'hFF))   miss_cnt <= miss_cnt + 8'd1;
`endif
endmodule

// File: tb/tb_restador_recuperador.sv
// tb_restador_recuperador: directed self-checking bench for restador_recuperador
module tb_restador_recuperador;
    logic       clk = 0;
    logic       reset_L = 0;
    logic       wr_valid = 0, rd_valid = 0;
    logic [3:0] idx = 0, dataB = 0, idx_dd = 0, sum30_dd = 0;
    logic [3:0] dataA_rec, idx_rec;
    logic       valid_rec, miss, overwrite;
    logic [7:0] cnt_rec;
`ifdef RESTADOR_MISSCNT_EN
    logic [7:0] miss_cnt;
`endif
    int n_cmp = 0, n_bad = 0;
    logic [3:0] a_op [300];
    logic [3:0] b_op [300];

    restador_recuperador dut (
        .clk(clk), .reset_L(reset_L), .wr_valid(wr_valid), .idx(idx), .dataB(dataB),
        .rd_valid(rd_valid), .idx_dd(idx_dd), .sum30_dd(sum30_dd),
        .dataA_rec(dataA_rec), .idx_rec(idx_rec), .valid_rec(valid_rec),
        .miss(miss), .overwrite(overwrite), .cnt_rec(cnt_rec)
`ifdef RESTADOR_MISSCNT_EN
        , .miss_cnt(miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [3:0] i, input logic [3:0] b,
                         input logic r, input logic [3:0] j, input logic [3:0] s);
        wr_valid = w; idx = i; dataB = b; rd_valid = r; idx_dd = j; sum30_dd = s;
    endtask

    task automatic idle;
        drive(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #2;
        chk("rst_dataA", dataA_rec, 0);
        chk("rst_idx", idx_rec, 0);
        chk("rst_valid", valid_rec, 0);
        chk("rst_miss", miss, 0);
        chk("rst_ovw", overwrite, 0);
        chk("rst_cnt", cnt_rec, 0);
        step;
        reset_L = 1;
        step;
        // basic recovery: 12 - 5 = 7
        drive(1, 3, 5, 0, 0, 0); step;
        idle; step;
        drive(0, 0, 0, 1, 3, 12); step;
        chk("basic_valid", valid_rec, 1);
        chk("basic_dataA", dataA_rec, 7);
        chk("basic_idx", idx_rec, 3);
        chk("basic_cnt", cnt_rec, 1);
        idle; step;
        chk("basic_valid_drop", valid_rec, 0);
        // wrap: 2 - 14 mod 16 = 4
        drive(1, 9, 14, 0, 0, 0); step;
        idle; step;
        drive(0, 0, 0, 1, 9, 2); step;
        chk("wrap_dataA", dataA_rec, 4);
        chk("wrap_cnt", cnt_rec, 2);
        // miss on never-written tag 6
        drive(0, 0, 0, 1, 6, 11); step;
        chk("miss_pulse", miss, 1);
        chk("miss_valid", valid_rec, 0);
        chk("miss_cnt_rec", cnt_rec, 2);
        chk("miss_hold_dataA", dataA_rec, 4);
        chk("miss_hold_idx", idx_rec, 9);
`ifdef RESTADOR_MISSCNT_EN
        chk("miss_cnt", miss_cnt, 1);
`endif
        idle; step;
        chk("miss_one_cycle", miss, 0);
        // same-tag bypass: 10 - 1 = 9
        drive(1, 2, 1, 1, 2, 10); step;
        chk("byp_valid", valid_rec, 1);
        chk("byp_dataA", dataA_rec, 9);
        chk("byp_idx", idx_rec, 2);
        chk("byp_ovw", overwrite, 0);
        chk("byp_cnt", cnt_rec, 3);
        drive(0, 0, 0, 1, 2, 10); step;
        chk("byp_second_miss", miss, 1);
        chk("byp_second_valid", valid_rec, 0);
        // reused occupied tag sets sticky overwrite; latest dataB is used
        drive(1, 5, 3, 0, 0, 0); step;
        chk("ovw_first", overwrite, 0);
        drive(1, 5, 6, 0, 0, 0); step;
        chk("ovw_set", overwrite, 1);
        drive(0, 0, 0, 1, 5, 1); step;
        chk("ovw_dataA", dataA_rec, 11);
        chk("ovw_sticky", overwrite, 1);
        // mid-stream reset: fill 0..3 while recovering tag 0
        drive(1, 0, 4, 0, 0, 0); step;
        drive(1, 1, 4, 1, 0, 9); step;
        drive(1, 0, 4, 0, 0, 0); step;
        drive(1, 2, 4, 0, 0, 0); step;
        drive(1, 3, 4, 0, 0, 0);
        chk("pre_rst_valid", valid_rec, 0);
        chk("pre_rst_cnt", cnt_rec, 5);
        #2 reset_L = 0;
        #1;
        chk("arst_dataA", dataA_rec, 0);
        chk("arst_idx", idx_rec, 0);
        chk("arst_ovw", overwrite, 0);
        chk("arst_cnt", cnt_rec, 0);
        chk("arst_valid", valid_rec, 0);
        chk("arst_miss", miss, 0);
        step;
        reset_L = 1;
        // write on the RST->RUN edge must be ignored
        drive(1, 7, 0, 0, 0, 0); step;
        drive(0, 0, 0, 1, 0, 0); step;
        chk("post_rst_miss0", miss, 1);
        drive(0, 0, 0, 1, 7, 0); step;
        chk("post_rst_ignored", miss, 1);
        chk("post_rst_cnt", cnt_rec, 0);
`ifdef RESTADOR_MISSCNT_EN
        chk("post_rst_miss_cnt", miss_cnt, 2);
`endif
        // stress: 300 operands, result two edges after issue
        for (int k = 0; k < 300; k++) begin
            a_op[k] = 4'($urandom_range(0, 15));
            b_op[k] = 4'($urandom_range(0, 15));
        end
        for (int k = 0; k < 302; k++) begin
            if (k < 300) begin wr_valid = 1; idx = 4'(k % 16); dataB = b_op[k]; end
            else wr_valid = 0;
            if (k >= 2) begin
                rd_valid = 1; idx_dd = 4'((k - 2) % 16); sum30_dd = a_op[k-2] + b_op[k-2];
            end else rd_valid = 0;
            step;
            if (k >= 2) begin
                chk("stress_valid", valid_rec, 1);
                chk("stress_dataA", dataA_rec, a_op[k-2]);
                chk("stress_miss", miss, 0);
            end
        end
        idle; step;
        chk("stress_cnt", cnt_rec, 44);
        chk("stress_ovw", overwrite, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end
endmodule
